gshare_branch_pred: RTL and testbench
=====================================

Name: gshare_branch_pred

Overview:
- Next-generation direction predictor for the decode stage. It is a gshare predictor: a table of saturating counters indexed by the PC XORed with a global history register (GHR).
- Counter width, table depth and history length are all parametrised.
- The block keeps a speculative GHR, updated at predict time, and an architectural GHR, updated at resolve time. A mispredict restores the speculative GHR from the resolving branch's history snapshot.
- After reset, the counter table is initialised by a hardware sweep.

Parameters:
- PC_BITWIDTH, 30, word-address PC width.
- INDEX_BITWIDTH, 8, log2 of table depth; table holds 2**INDEX_BITWIDTH counters.
- GHRWIDTH, 8, history length; must satisfy 2 <= GHRWIDTH <= INDEX_BITWIDTH.
- CTR_BITWIDTH, 2, saturating counter width (>=1).

Ports:
- clk  in  1  clock
- sync_rst  in  1  synchronous active-high reset
- clk_en  in  1  global stall-low enable; when 0, all state holds
- lookup_valid  in  1  request a prediction this cycle
- lookup_pc  in  PC_BITWIDTH  PC of the instruction being predicted
- pred_valid  out  1  prediction result valid (registered)
- pred_taken  out  1  counter MSB of the looked-up entry
- pred_ghr  out  GHRWIDTH  speculative GHR used for the lookup; carried down the pipe as a snapshot
- spec_push  in  1  decode committed a conditional-branch prediction; shift spec_dir into the speculative GHR
- spec_dir  in  1  predicted direction to push
- update_valid  in  1  a branch resolved in execute
- update_pc  in  PC_BITWIDTH  PC of the resolved branch
- update_ghr  in  GHRWIDTH  snapshot returned with that branch
- update_taken  in  1  actual outcome
- update_mispredict  in  1  prediction was wrong
- arch_ghr  out  GHRWIDTH  committed history (debug/perf)
- init_busy  out  1  table sweep in progress

Behaviour:
- Index is lookup_pc[INDEX_BITWIDTH-1:0] XOR (speculative GHR zero-extended to INDEX_BITWIDTH). Update index is formed the same way from update_pc and update_ghr.
- State machine has two states, INIT and RUN.
  - sync_rst, from any state and mid-operation, goes to INIT. It sets sweep pointer = 0, both GHRs = 0, pred_valid = 0, pred_taken = 0, pred_ghr = 0, and init_busy = 1.
  - In INIT, each clk_en cycle writes the weakly-not-taken value (2**(CTR_BITWIDTH-1)-1) to entry[ptr] and increments ptr. When ptr reaches the last index, that entry is written and the state moves to RUN.
  - Sweep length is exactly 2**INDEX_BITWIDTH enabled cycles; then init_busy = 0.
- During INIT, lookups produce pred_valid = 0, and update/spec_push are ignored.
- Lookup in RUN has 1-cycle latency. On an enabled edge, pred_valid <= lookup_valid, pred_taken <= entry[idx][MSB], and pred_ghr <= spec GHR. Outputs hold while clk_en = 0.
- spec_push: spec GHR <= {spec GHR[GHRWIDTH-2:0], spec_dir}.
- update_valid:
  - The counter at the update index saturates: +1 on taken, capped at all-ones; -1 on not-taken, floored at 0.
  - arch_ghr shifts in update_taken.
  - If update_mispredict, spec GHR <= {update_ghr[GHRWIDTH-2:0], update_taken}. This takes priority over a simultaneous spec_push.
- Counter read for the update is combinational (second read port); the write happens on the same edge.
- Lookup and update to the same index in the same cycle: without the optional feature, the lookup returns the pre-update value (read-before-write).
- Deasserting clk_en freezes FSM, sweep pointer, GHRs, table and outputs.

Optional Feature:
- Macro GSHARE_UPDATE_BYPASS_EN.
- When defined, a same-cycle lookup and update hitting the same index return the post-update counter MSB. The lookup index uses the pre-restore spec GHR.
- When undefined, the lookup returns the old value. The extra compare/mux logic is absent.

Decomposition:
- Package bp_pkg holds:
  - the typedef enum for the FSM (BP_INIT, BP_RUN);
  - function sat_next(ctr, taken) parametrised by width via a let/parameterised class, or explicit width arg;
  - function gshare_index(pc, ghr).
- One sub-module, bp_counter_table. It has 1 synchronous read port, 1 asynchronous read port and 1 write port, with depth and width parameters. It holds the storage only; the FSM and GHRs stay in the top.

Test Plan:
- Reset sweep: pulse sync_rst, clk_en = 1 → init_busy = 1 for exactly 256 cycles (default params), pred_valid = 0 throughout. Then every index predicts not-taken (counter = 1).
- Saturation: three updates taken at pc = 0x10, ghr = 0 → counter reaches 3 and holds at 3 after a 4th. Lookup then gives pred_taken = 1 one cycle later. Four not-taken → 0 and holds at 0.
- History and index: spec_push with dirs 1,0,1 → pred_ghr = 0x05. Lookup pc = 0x05 indexes entry 0x00. Prior training of entry 0 to taken → pred_taken = 1.
- Mispredict restore: spec GHR = 0x0F, update_mispredict with update_ghr = 0x03 and taken = 0, plus simultaneous spec_push → spec GHR = 0x06, arch_ghr shifted once.
- Same-index collision: entry at counter 1, simultaneous lookup and taken-update to that index → pred_taken = 0 without the macro, 1 with GSHARE_UPDATE_BYPASS_EN.
- Stall and mid-run reset: clk_en = 0 for 5 cycles → outputs/GHRs unchanged. sync_rst asserted during RUN → re-enters INIT, GHRs = 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare direction predictor:
// FSM state encoding, saturating-counter step and table index hash.
package bp_pkg;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    // Saturating step of a counter that is 'width' bits wide.
    // The value is carried in 32 bits so one function serves every counter width.
    function automatic logic [31:0] sat_next(input logic [31:0] ctr,
                                             input logic        taken,
                                             input int          width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        if (taken) begin
            return (ctr >= max_val) ? max_val : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

    // gshare hash: low PC bits XOR the zero-extended history, masked to the index width.
    function automatic logic [31:0] gshare_index(input logic [31:0] pc,
                                                 input logic [31:0] ghr,
                                                 input int          idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (pc ^ ghr) & mask;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Counter storage for the predictor: one registered read port for lookups,
// one combinational read port for the resolve-time read-modify-write, and
// one write port. A registered read that collides with a write returns the old data.
module bp_counter_table #(
    parameter int DEPTH_BITS = 8,
    parameter int WIDTH      = 2
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [DEPTH_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    input  logic [DEPTH_BITS-1:0] ard_addr,
    output logic [WIDTH-1:0]      ard_data,
    input  logic                  wr_en,
    input  logic [DEPTH_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data
);

    logic [WIDTH-1:0] mem_reg [2**DEPTH_BITS];
    logic [WIDTH-1:0] rd_data_reg;

    // Write port and registered read port share one edge (read-before-write).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data  = rd_data_reg;
    assign ard_data = mem_reg[ard_addr];

endmodule

// File: rtl/gshare_branch_pred.sv
// gshare direction predictor: saturating-counter table indexed by PC XOR history,
// with a speculative history (shifted at predict time, restored on mispredict)
// and an architectural history (shifted at resolve time). The table is cleared
// to weakly-not-taken by a sweep after reset.
// Optional build macro: GSHARE_UPDATE_BYPASS_EN forwards a same-cycle update
// result to a lookup hitting the same entry; otherwise the lookup sees the old value.
module gshare_branch_pred
    import bp_pkg::*;
#(
    parameter int PC_BITWIDTH    = 30,
    parameter int INDEX_BITWIDTH = 8,
    parameter int GHRWIDTH       = 8,
    parameter int CTR_BITWIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   sync_rst,
    input  logic                   clk_en,
    input  logic                   lookup_valid,
    input  logic [PC_BITWIDTH-1:0] lookup_pc,
    output logic                   pred_valid,
    output logic                   pred_taken,
    output logic [GHRWIDTH-1:0]    pred_ghr,
    input  logic                   spec_push,
    input  logic                   spec_dir,
    input  logic                   update_valid,
    input  logic [PC_BITWIDTH-1:0] update_pc,
    input  logic [GHRWIDTH-1:0]    update_ghr,
    input  logic                   update_taken,
    input  logic                   update_mispredict,
    output logic [GHRWIDTH-1:0]    arch_ghr,
    output logic                   init_busy
);

    localparam logic [INDEX_BITWIDTH-1:0] LAST_IDX = INDEX_BITWIDTH'((2**INDEX_BITWIDTH) - 1);
    localparam logic [CTR_BITWIDTH-1:0]   WNT_VAL  = CTR_BITWIDTH'((2**(CTR_BITWIDTH-1)) - 1);

    bp_state_t                 state_reg;
    logic [INDEX_BITWIDTH-1:0] ptr_reg;
    logic [GHRWIDTH-1:0]       spec_ghr_reg;
    logic [GHRWIDTH-1:0]       arch_ghr_reg;
    logic                      pred_valid_reg;
    logic [GHRWIDTH-1:0]       pred_ghr_reg;
    logic                      rd_gate_reg;
    logic                      init_busy_reg;

    logic [INDEX_BITWIDTH-1:0] lookup_idx;
    logic [INDEX_BITWIDTH-1:0] update_idx;
    logic [CTR_BITWIDTH-1:0]   upd_ctr;
    logic [CTR_BITWIDTH-1:0]   upd_ctr_next;
    logic [CTR_BITWIDTH-1:0]   rd_ctr;
    logic                      run_en;
    logic                      init_en;
    logic                      upd_en;
    logic                      wr_en;
    logic [INDEX_BITWIDTH-1:0] wr_addr;
    logic [CTR_BITWIDTH-1:0]   wr_data;
    logic                      lookup_msb;

    assign lookup_idx   = INDEX_BITWIDTH'(gshare_index(32'(lookup_pc), 32'(spec_ghr_reg), INDEX_BITWIDTH));
    assign update_idx   = INDEX_BITWIDTH'(gshare_index(32'(update_pc), 32'(update_ghr), INDEX_BITWIDTH));
    assign upd_ctr_next = CTR_BITWIDTH'(sat_next(32'(upd_ctr), update_taken, CTR_BITWIDTH));

    // Reset wins over everything; the table is only touched on enabled edges.
    assign run_en  = clk_en & ~sync_rst & (state_reg == BP_RUN);
    assign init_en = clk_en & ~sync_rst & (state_reg == BP_INIT);
    assign upd_en  = run_en & update_valid;

    // The sweep owns the write port during INIT; resolves own it during RUN.
    always_comb begin
        wr_en   = init_en | upd_en;
        wr_addr = update_idx;
        wr_data = upd_ctr_next;
        if (init_en) begin
            wr_addr = ptr_reg;
            wr_data = WNT_VAL;
        end
    end

    bp_counter_table #(
        .DEPTH_BITS (INDEX_BITWIDTH),
        .WIDTH      (CTR_BITWIDTH)
    ) u_table (
        .clk      (clk),
        .rd_en    (run_en),
        .rd_addr  (lookup_idx),
        .rd_data  (rd_ctr),
        .ard_addr (update_idx),
        .ard_data (upd_ctr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

`ifdef GSHARE_UPDATE_BYPASS_EN
    logic byp_hit_reg;
    logic byp_val_reg;

    // Capture whether this lookup collided with the update being written.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            byp_hit_reg <= 1'b0;
            byp_val_reg <= 1'b0;
        end else if (run_en) begin
            byp_hit_reg <= update_valid && (lookup_idx == update_idx);
            byp_val_reg <= upd_ctr_next[CTR_BITWIDTH-1];
        end
    end

    assign lookup_msb = byp_hit_reg ? byp_val_reg : rd_ctr[CTR_BITWIDTH-1];
`else
    assign lookup_msb = rd_ctr[CTR_BITWIDTH-1];
`endif

    // Control FSM, sweep pointer, both histories and the registered prediction fields.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_reg      <= BP_INIT;
            ptr_reg        <= '0;
            spec_ghr_reg   <= '0;
            arch_ghr_reg   <= '0;
            pred_valid_reg <= 1'b0;
            pred_ghr_reg   <= '0;
            rd_gate_reg    <= 1'b0;
            init_busy_reg  <= 1'b1;
        end else if (clk_en) begin
            case (state_reg)
                BP_INIT: begin
                    pred_valid_reg <= 1'b0;
                    ptr_reg        <= ptr_reg + INDEX_BITWIDTH'(1);
                    if (ptr_reg == LAST_IDX) begin
                        state_reg     <= BP_RUN;
                        init_busy_reg <= 1'b0;
                    end
                end
                BP_RUN: begin
                    pred_valid_reg <= lookup_valid;
                    pred_ghr_reg   <= spec_ghr_reg;
                    rd_gate_reg    <= 1'b1;
                    if (update_valid) begin
                        arch_ghr_reg <= {arch_ghr_reg[GHRWIDTH-2:0], update_taken};
                    end
                    // A mispredict restore overrides a speculative push in the same cycle.
                    if (update_valid && update_mispredict) begin
                        spec_ghr_reg <= {update_ghr[GHRWIDTH-2:0], update_taken};
                    end else if (spec_push) begin
                        spec_ghr_reg <= {spec_ghr_reg[GHRWIDTH-2:0], spec_dir};
                    end
                end
                default: begin
                    state_reg <= BP_INIT;
                end
            endcase
        end
    end

    assign pred_valid = pred_valid_reg;
    assign pred_taken = rd_gate_reg & lookup_msb;
    assign pred_ghr   = pred_ghr_reg;
    assign arch_ghr   = arch_ghr_reg;
    assign init_busy  = init_busy_reg;

endmodule

// File: tb/tb_gshare_branch_pred.sv
// Directed scoreboard bench for gshare_branch_pred (default parameters).
// Lookups push their hand-computed expected result into a queue; a monitor pops
// and compares whenever the DUT presents a fresh pred_valid.
module tb_gshare_branch_pred;

    logic        clk;
    logic        sync_rst;
    logic        clk_en;
    logic        lookup_valid;
    logic [29:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [7:0]  pred_ghr;
    logic        spec_push;
    logic        spec_dir;
    logic        update_valid;
    logic [29:0] update_pc;
    logic [7:0]  update_ghr;
    logic        update_taken;
    logic        update_mispredict;
    logic [7:0]  arch_ghr;
    logic        init_busy;

    gshare_branch_pred dut (
        .clk               (clk),
        .sync_rst          (sync_rst),
        .clk_en            (clk_en),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .pred_valid        (pred_valid),
        .pred_taken        (pred_taken),
        .pred_ghr          (pred_ghr),
        .spec_push         (spec_push),
        .spec_dir          (spec_dir),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_ghr        (update_ghr),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .arch_ghr          (arch_ghr),
        .init_busy         (init_busy)
    );

`ifdef GSHARE_UPDATE_BYPASS_EN
    localparam logic COLLIDE_EXP = 1'b1;
`else
    localparam logic COLLIDE_EXP = 1'b0;
`endif

    typedef struct {
        logic       taken;
        logic [7:0] ghr;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic en_at_edge = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Remember whether the most recent rising edge was enabled.
    always @(posedge clk) en_at_edge <= clk_en;

    // Monitor: compares each fresh prediction against the scoreboard head.
    always @(negedge clk) begin
        if (en_at_edge && pred_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pred: pred_valid=1 with no lookup pending (required none)");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, ".taken"}, 32'(pred_taken), 32'(e.taken));
                check({e.name, ".ghr"}, 32'(pred_ghr), 32'(e.ghr));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        lookup_valid      = 1'b0;
        lookup_pc         = '0;
        spec_push         = 1'b0;
        spec_dir          = 1'b0;
        update_valid      = 1'b0;
        update_pc         = '0;
        update_ghr        = '0;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    task automatic set_lookup(input logic [29:0] pc, input logic exp_tk, input logic [7:0] exp_g,
                              input string name);
        exp_t e;
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        e.taken = exp_tk;
        e.ghr   = exp_g;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic set_update(input logic [29:0] pc, input logic [7:0] g, input logic tk, input logic mp);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_ghr        = g;
        update_taken      = tk;
        update_mispredict = mp;
    endtask

    task automatic do_lookup(input logic [29:0] pc, input logic exp_tk, input logic [7:0] exp_g,
                             input string name);
        set_lookup(pc, exp_tk, exp_g, name);
        tick();
        idle();
    endtask

    task automatic do_update(input logic [29:0] pc, input logic [7:0] g, input logic tk, input logic mp);
        set_update(pc, g, tk, mp);
        tick();
        idle();
    endtask

    task automatic do_push(input logic dir);
        spec_push = 1'b1;
        spec_dir  = dir;
        tick();
        idle();
    endtask

    // Assert reset for rst_cycles, check the reset state, then measure the sweep
    // while driving junk lookups/updates/pushes that must all be ignored.
    task automatic reset_and_sweep(input int rst_cycles, input string tag);
        int cnt;
        bit done;
        sync_rst = 1'b1;
        clk_en   = 1'b1;
        idle();
        for (int i = 0; i < rst_cycles; i++) tick();
        sync_rst = 1'b0;
        check({tag, ".rst_init_busy"}, 32'(init_busy), 32'd1);
        check({tag, ".rst_pred_valid"}, 32'(pred_valid), 32'd0);
        check({tag, ".rst_pred_taken"}, 32'(pred_taken), 32'd0);
        check({tag, ".rst_pred_ghr"}, 32'(pred_ghr), 32'd0);
        check({tag, ".rst_arch_ghr"}, 32'(arch_ghr), 32'd0);
        lookup_valid = 1'b1;
        lookup_pc    = 30'h10;
        spec_push    = 1'b1;
        spec_dir     = 1'b1;
        set_update(30'h0, 8'h00, 1'b1, 1'b1);
        cnt  = 1;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (!init_busy) begin
                done = 1'b1;
                break;
            end
            cnt++;
        end
        idle();
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.sweep_timeout: init_busy still 1 after 2000 cycles (required 256)", tag);
        end else begin
            check({tag, ".sweep_len"}, 32'(cnt), 32'd256);
        end
    endtask

    initial begin
        sync_rst = 1'b1;
        clk_en   = 1'b1;
        idle();

        // Reset sweep; everything predicts weakly-not-taken afterwards.
        reset_and_sweep(2, "init");
        do_lookup(30'h000,      1'b0, 8'h00, "post_init_pc00");
        do_lookup(30'h0FF,      1'b0, 8'h00, "post_init_pcFF");
        do_lookup(30'h3FFF_FF7F, 1'b0, 8'h00, "post_init_pc7F_hi");
        do_lookup(30'h010,      1'b0, 8'h00, "post_init_pc10");

        // Saturation at the top and bottom of entry 0x10.
        for (int i = 0; i < 4; i++) do_update(30'h10, 8'h00, 1'b1, 1'b0);
        do_lookup(30'h10, 1'b1, 8'h00, "sat_hi_3");
        do_update(30'h10, 8'h00, 1'b0, 1'b0);
        do_lookup(30'h10, 1'b1, 8'h00, "sat_hi_2");
        do_update(30'h10, 8'h00, 1'b0, 1'b0);
        do_lookup(30'h10, 1'b0, 8'h00, "sat_1");
        for (int i = 0; i < 4; i++) do_update(30'h10, 8'h00, 1'b0, 1'b0);
        do_update(30'h10, 8'h00, 1'b1, 1'b0);
        do_lookup(30'h10, 1'b0, 8'h00, "sat_lo_1");
        do_update(30'h10, 8'h00, 1'b1, 1'b0);
        do_lookup(30'h10, 1'b1, 8'h00, "sat_lo_2");
        check("arch_after_sat", 32'(arch_ghr), 32'h03);

        // History and index: train entry 0, then reach it through GHR 0x05.
        do_update(30'h0, 8'h00, 1'b1, 1'b0);
        do_update(30'h0, 8'h00, 1'b1, 1'b0);
        check("arch_after_train", 32'(arch_ghr), 32'h0F);
        do_push(1'b1);
        do_push(1'b0);
        do_push(1'b1);
        do_lookup(30'h05, 1'b1, 8'h05, "hist_idx0");
        do_lookup(30'h10, 1'b0, 8'h05, "hist_idx15");
        spec_push = 1'b1;
        spec_dir  = 1'b1;
        do_lookup(30'h00, 1'b0, 8'h05, "lookup_with_push");

        // Mispredict restore with a competing push.
        for (int i = 0; i < 8; i++) do_push(i >= 4);
        do_lookup(30'h80, 1'b0, 8'h0F, "ghr_0F");
        spec_push = 1'b1;
        spec_dir  = 1'b1;
        do_update(30'h03, 8'h03, 1'b0, 1'b1);
        check("arch_after_mp", 32'(arch_ghr), 32'h1E);
        do_lookup(30'h06, 1'b1, 8'h06, "restored_ghr");

        // Same-cycle lookup and update on entry 0x20.
        set_update(30'h20, 8'h00, 1'b1, 1'b0);
        do_lookup(30'h26, COLLIDE_EXP, 8'h06, "collision");
        do_lookup(30'h26, 1'b1, 8'h06, "after_collision");

        // Stall: outputs, histories and table must hold.
        clk_en = 1'b0;
        lookup_valid = 1'b1;
        lookup_pc    = 30'h10;
        spec_push    = 1'b1;
        spec_dir     = 1'b1;
        set_update(30'h20, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall%0d.pred_valid", i), 32'(pred_valid), 32'd1);
            check($sformatf("stall%0d.pred_taken", i), 32'(pred_taken), 32'd1);
            check($sformatf("stall%0d.pred_ghr", i), 32'(pred_ghr), 32'h06);
            check($sformatf("stall%0d.arch_ghr", i), 32'(arch_ghr), 32'h3D);
        end
        idle();
        clk_en = 1'b1;
        do_lookup(30'h26, 1'b1, 8'h06, "after_stall");

        // Mid-run reset re-enters INIT and clears the histories and table.
        spec_push = 1'b1;
        spec_dir  = 1'b1;
        do_lookup(30'h00, 1'b0, 8'h06, "before_rerst");
        reset_and_sweep(1, "rerst");
        do_lookup(30'h26, 1'b0, 8'h00, "rerst_pc26");
        do_lookup(30'h00, 1'b0, 8'h00, "rerst_pc00");
        check("rerst_arch_ghr", 32'(arch_ghr), 32'h00);

        tick();
        tick();
        check("pending_lookups", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
